// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, total-length helper, sync polarity and the
// registered output bundle used by vga_sync_gen and pattern-generator consumers.
package vga_pkg;

    localparam int H_VIS_DEF = 640;
    localparam int H_FP_DEF  = 16;
    localparam int H_SW_DEF  = 96;
    localparam int H_BP_DEF  = 48;

    localparam int V_VIS_DEF = 480;
    localparam int V_FP_DEF  = 10;
    localparam int V_SW_DEF  = 2;
    localparam int V_BP_DEF  = 33;

    localparam int CNT_W = 10;
    localparam int ROW_W = 9;
    localparam int COL_W = 10;

    // Both syncs are active-low for the 640x480 mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic int vga_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    localparam int H_TOT_DEF = vga_total(H_VIS_DEF, H_FP_DEF, H_SW_DEF, H_BP_DEF);
    localparam int V_TOT_DEF = vga_total(V_VIS_DEF, V_FP_DEF, V_SW_DEF, V_BP_DEF);

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             video_on;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             frame_start;
    } vga_out_t;

    localparam vga_out_t VGA_OUT_RST = '{
        hsync:       ~SYNC_ACTIVE,
        vsync:       ~SYNC_ACTIVE,
        video_on:    1'b0,
        row:         '0,
        col:         '0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/vga_mod_cnt.sv
// Modulo-MOD counter with enable, exposing its next-state value and a
// wrap strobe (enabled while sitting at MOD-1) for cascading.
module vga_mod_cnt
    import vga_pkg::*;
#(
    parameter int MOD = H_TOT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_nxt,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_wrap = i_en && (r_cnt == LAST);

    // NOTE: o_nxt gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        o_nxt = r_cnt;
        if (i_en) begin
            o_nxt = o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator with registered outputs decoded from next-state counters.
// Optional macro VGA_PIX_DIV2_EN: pixel tick every second clock (toggle divider).
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VIS = H_VIS_DEF,
    parameter int H_FP  = H_FP_DEF,
    parameter int H_SW  = H_SW_DEF,
    parameter int H_BP  = H_BP_DEF,
    parameter int V_VIS = V_VIS_DEF,
    parameter int V_FP  = V_FP_DEF,
    parameter int V_SW  = V_SW_DEF,
    parameter int V_BP  = V_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             video_on_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] colum_o,
    output logic             pix_tick_o,
    output logic             frame_start_o
);

    localparam int H_TOT = vga_total(H_VIS, H_FP, H_SW, H_BP);
    localparam int V_TOT = vga_total(V_VIS, V_FP, V_SW, V_BP);

    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SW - 1);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SW - 1);

    logic             w_tick;
    logic             r_primed;
    logic             w_h_en;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    vga_out_t         w_nxt;
    vga_out_t         r_out;
    logic             r_pix_tick;

`ifdef VGA_PIX_DIV2_EN
    logic r_div;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div <= 1'b0;
        end else begin
            r_div <= ~r_div;
        end
    end

    assign w_tick = r_div;
`else
    assign w_tick = 1'b1;
`endif

    // The first tick after reset presents pixel (0,0) without advancing the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_primed <= 1'b0;
        end else if (w_tick) begin
            r_primed <= 1'b1;
        end
    end

    assign w_h_en = w_tick & r_primed;

    vga_mod_cnt #(.MOD(H_TOT)) u_hcnt (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_en   (w_h_en),
        .o_nxt  (w_h_nxt),
        .o_wrap (w_h_wrap)
    );

    vga_mod_cnt #(.MOD(V_TOT)) u_vcnt (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_en   (w_h_wrap),
        .o_nxt  (w_v_nxt),
        .o_wrap (w_v_wrap)
    );

    always_comb begin
        w_nxt          = VGA_OUT_RST;
        w_nxt.video_on = (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
        w_nxt.hsync    = ((w_h_nxt >= HS_BEG) && (w_h_nxt <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_nxt.vsync    = ((w_v_nxt >= VS_BEG) && (w_v_nxt <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        if (w_nxt.video_on) begin
            w_nxt.row = w_v_nxt[ROW_W-1:0];
            w_nxt.col = w_h_nxt;
        end
        // Next pixel is (0,0) either on a frame wrap or on the priming tick.
        w_nxt.frame_start = w_v_wrap | ~r_primed;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out      <= VGA_OUT_RST;
            r_pix_tick <= 1'b0;
        end else begin
            r_pix_tick <= w_tick;
            if (w_tick) begin
                r_out <= w_nxt;
            end
        end
    end

    assign hsync_o       = r_out.hsync;
    assign vsync_o       = r_out.vsync;
    assign video_on_o    = r_out.video_on;
    assign row_o         = r_out.row;
    assign colum_o       = r_out.col;
    assign frame_start_o = r_out.frame_start;
    assign pix_tick_o    = r_pix_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken timing so full frames fit in a short run.
// Expected outputs come from a linear pixel-index model; honours VGA_PIX_DIV2_EN.
module tb_vga_sync_gen;

    localparam int H_VIS = 16;
    localparam int H_FP  = 4;
    localparam int H_SW  = 6;
    localparam int H_BP  = 4;
    localparam int V_VIS = 16;
    localparam int V_FP  = 2;
    localparam int V_SW  = 2;
    localparam int V_BP  = 3;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int BAND  = V_VIS / 8;
`ifdef VGA_PIX_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    typedef logic [23:0] obs_t;

    logic       clk_i;
    logic       rst_i;
    logic       hsync_o;
    logic       vsync_o;
    logic       video_on_o;
    logic [8:0] row_o;
    logic [9:0] colum_o;
    logic       pix_tick_o;
    logic       frame_start_o;

    int   n_checks;
    int   n_errors;
    int   c_rel;
    obs_t exp_q[$];

    vga_sync_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .video_on_o    (video_on_o),
        .row_o         (row_o),
        .colum_o       (colum_o),
        .pix_tick_o    (pix_tick_o),
        .frame_start_o (frame_start_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // c = clock edges since reset release (0 while in reset).
    function automatic obs_t model(input int c);
        int   k;
        int   p;
        int   h;
        int   v;
        logic pt;
        logic vis;
        logic hs;
        logic vs;
        logic [8:0] r;
        logic [9:0] cl;
        if (c == 0) return {1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 1'b0};
        k  = c / DIV;
        pt = ((c % DIV) == 0);
        if (k == 0) return {pt, 1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 1'b0};
        p   = (k - 1) % FRAME;
        h   = p % H_TOT;
        v   = p / H_TOT;
        vis = (h < H_VIS) && (v < V_VIS);
        hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SW));
        vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SW));
        r   = vis ? 9'(v) : 9'd0;
        cl  = vis ? 10'(h) : 10'd0;
        return {pt, hs, vs, vis, r, cl, (p == 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r);
        obs_t got;
        obs_t e;
        rst_i = r;
        if (r) c_rel = 0;
        else   c_rel++;
        exp_q.push_back(model(c_rel));
        @(posedge clk_i);
        #1;
        got = {pix_tick_o, hsync_o, vsync_o, video_on_o, row_o, colum_o, frame_start_o};
        e   = exp_q.pop_front();
        check($sformatf("cycle_rel%0d", c_rel), {8'd0, got}, {8'd0, e});
    endtask

    initial begin
        int fs_t[$];
        int t0;
        int hs_fall;
        int vs_fall;
        int hs_low;
        int von_cnt;
        int vs_low;
        int pt_high;
        int blank_bad;
        int band_chg;
        int band_bad;
        int last_band;
        bit have_band;
        bit prev_fs;
        bit prev_hs;
        bit prev_vs;
        bit found;
        int n_run;

        n_checks = 0;
        n_errors = 0;
        c_rel    = 0;
        rst_i    = 1'b1;

        // Reset held for three clocks.
        repeat (3) step(1'b1);
        check("rst_hsync", hsync_o, 1);
        check("rst_vsync", vsync_o, 1);
        check("rst_video_on", video_on_o, 0);
        check("rst_row", row_o, 0);
        check("rst_col", colum_o, 0);

        // Two-plus frames from release with timing measurements.
        t0 = -1; hs_fall = -1; vs_fall = -1;
        hs_low = 0; von_cnt = 0; vs_low = 0; pt_high = 0;
        blank_bad = 0; band_chg = 0; band_bad = 0; last_band = 0; have_band = 0;
        prev_fs = 0; prev_hs = 1; prev_vs = 1;
        n_run = 2 * FRAME * DIV + 2 * DIV;
        for (int i = 0; i < n_run; i++) begin
            step(1'b0);
            if (pix_tick_o) pt_high++;
            if (!video_on_o && (row_o != 0 || colum_o != 0)) blank_bad++;
            if (frame_start_o && !prev_fs) begin
                fs_t.push_back(c_rel);
                if (t0 < 0) t0 = c_rel;
            end
            if (t0 >= 0 && (c_rel - t0) < H_TOT * DIV) begin
                if (!hsync_o) hs_low++;
                if (video_on_o) von_cnt++;
                if (!hsync_o && prev_hs && hs_fall < 0) hs_fall = c_rel - t0;
            end
            if (t0 >= 0 && (c_rel - t0) < FRAME * DIV) begin
                if (!vsync_o) vs_low++;
                if (!vsync_o && prev_vs && vs_fall < 0) vs_fall = c_rel - t0;
                if (video_on_o) begin
                    if (have_band && (row_o / BAND) != last_band && row_o != 0) begin
                        band_chg++;
                        if ((row_o % BAND) != 0 || colum_o != 0) band_bad++;
                    end
                    last_band = row_o / BAND;
                    have_band = 1;
                end
            end
            prev_fs = frame_start_o;
            prev_hs = hsync_o;
            prev_vs = vsync_o;
        end

        check("first_frame_start", t0, DIV);
        check("hs_start", hs_fall, (H_VIS + H_FP) * DIV);
        check("hs_width", hs_low, H_SW * DIV);
        check("video_on_width", von_cnt, H_VIS * DIV);
        check("vs_start", vs_fall, (V_VIS + V_FP) * H_TOT * DIV);
        check("vs_width", vs_low, V_SW * H_TOT * DIV);
        check("pix_tick_count", pt_high, n_run / DIV);
        check("blank_coords", blank_bad, 0);
        check("band_changes", band_chg, 7);
        check("band_boundary", band_bad, 0);
        check("fs_seen", (fs_t.size() >= 2), 1);
        if (fs_t.size() >= 2) check("frame_period", fs_t[1] - fs_t[0], FRAME * DIV);

        // Run to pixel h=22 (inside hsync), v=8, then pulse reset mid-frame.
        found = 0;
        for (int i = 0; i < 2 * FRAME * DIV && !found; i++) begin
            step(1'b0);
            if ((c_rel % DIV) == 0 && ((c_rel / DIV - 1) % FRAME) == 8 * H_TOT + 22) found = 1;
        end
        check("mid_reached", found, 1);
        check("mid_hs_low", hsync_o, 0);
        step(1'b1);
        check("mid_rst_hsync", hsync_o, 1);
        check("mid_rst_frame_start", frame_start_o, 0);
        repeat (DIV) step(1'b0);
        check("mid_row", row_o, 0);
        check("mid_col", colum_o, 0);
        check("mid_video_on", video_on_o, 1);
        check("mid_frame_start", frame_start_o, 1);
        repeat (3 * H_TOT * DIV) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
